// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one divider between NUM_REQ requesters.
// Optional watchdog on the divider result: define DIV_TIMEOUT_EN.
module divider_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int DIVIDEND_W     = 64,
   parameter int DIVISOR_W      = 32,
   parameter int TIMEOUT_CYCLES = 128
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DIVIDEND_W-1:0] req_dividend,
   input  logic [NUM_REQ*DIVISOR_W-1:0]  req_divisor,
   output logic [NUM_REQ-1:0]            rsp_valid,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic [DIVIDEND_W-1:0]         rsp_quotient,
   output logic [DIVISOR_W-1:0]          rsp_remainder,
   output logic                          rsp_overflow,
   output logic                          div_start,
   output logic [DIVIDEND_W-1:0]         div_dividend,
   output logic [DIVISOR_W-1:0]          div_divisor,
   input  logic [DIVIDEND_W-1:0]         div_quotient,
   input  logic [DIVISOR_W-1:0]          div_remainder,
   input  logic                          div_overflow,
   input  logic                          div_valid_out
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t             state;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_found;
   logic [NUM_REQ-1:0] grant_onehot;

`ifdef DIV_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;
   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // Two passes give the wrap-around search: indices above last_grant first, then the rest.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && req_valid[i] && (IDX_W'(i) > last_grant)) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && req_valid[i] && (IDX_W'(i) <= last_grant)) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(i);
         end
      end
   end

   assign grant_onehot = NUM_REQ'(1) << grant_idx;
   assign req_ready    = (state == IDLE && grant_found && !reset) ? grant_onehot : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         last_grant    <= IDX_W'(NUM_REQ - 1);
         owner         <= '0;
         rsp_valid     <= '0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
         rsp_overflow  <= 1'b0;
         div_start     <= 1'b0;
         div_dividend  <= '0;
         div_divisor   <= '0;
`ifdef DIV_TIMEOUT_EN
         wait_cnt      <= '0;
`endif
      end else begin
         div_start <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_found) begin
                  div_dividend <= req_dividend[grant_idx*DIVIDEND_W +: DIVIDEND_W];
                  div_divisor  <= req_divisor[grant_idx*DIVISOR_W +: DIVISOR_W];
                  owner        <= grant_idx;
                  div_start    <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
`ifdef DIV_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            WAIT: begin
               if (div_valid_out) begin
                  rsp_quotient  <= div_quotient;
                  rsp_remainder <= div_remainder;
                  rsp_overflow  <= div_overflow;
                  rsp_valid     <= NUM_REQ'(1) << owner;
                  state         <= RESP;
               end
`ifdef DIV_TIMEOUT_EN
               else if (timeout_hit) begin
                  rsp_quotient  <= '1;
                  rsp_remainder <= '0;
                  rsp_overflow  <= 1'b1;
                  rsp_valid     <= NUM_REQ'(1) << owner;
                  state         <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               // Operands and result stay frozen here until the owner takes the result.
               if (rsp_ready[owner]) begin
                  rsp_valid  <= '0;
                  last_grant <= owner;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter; the bench plays the divider and the requesters.
module tb_divider_arbiter;

   localparam int NR  = 2;
   localparam int DW  = 64;
   localparam int SW  = 32;
   localparam int TMO = 16;

   logic              clk;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*DW-1:0]  req_dividend;
   logic [NR*SW-1:0]  req_divisor;
   logic [NR-1:0]     rsp_valid;
   logic [NR-1:0]     rsp_ready;
   logic [DW-1:0]     rsp_quotient;
   logic [SW-1:0]     rsp_remainder;
   logic              rsp_overflow;
   logic              div_start;
   logic [DW-1:0]     div_dividend;
   logic [SW-1:0]     div_divisor;
   logic [DW-1:0]     div_quotient;
   logic [SW-1:0]     div_remainder;
   logic              div_overflow;
   logic              div_valid_out;

   int checks   = 0;
   int failures = 0;

   divider_arbiter #(
      .NUM_REQ(NR), .DIVIDEND_W(DW), .DIVISOR_W(SW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_overflow(rsp_overflow),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder),
      .div_overflow(div_overflow), .div_valid_out(div_valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction for requester g whose req_valid is already high.
   task automatic run_txn(input int g, input logic [63:0] dvd, input logic [31:0] dvs,
                          input int d, input logic [63:0] q, input logic [31:0] r,
                          input logic ovf, input int hold);
      req_dividend[g*DW +: DW] = dvd;
      req_divisor[g*SW +: SW]  = dvs;
      #1;
      chk("grant_ready", 64'(req_ready), 64'(1) << g);
      step();
      chk("start_pulse", 64'(div_start), 64'd1);
      chk("op_dividend", div_dividend, dvd);
      chk("op_divisor", 64'(div_divisor), 64'(dvs));
      chk("ready_issue", 64'(req_ready), 64'd0);
      step();
      chk("start_single", 64'(div_start), 64'd0);
      repeat (d - 1) step();
      chk("no_early_rsp", 64'(rsp_valid), 64'd0);
      div_valid_out = 1'b1;
      div_quotient  = q;
      div_remainder = r;
      div_overflow  = ovf;
      step();
      div_valid_out = 1'b0;
      div_quotient  = '1;
      div_remainder = '1;
      div_overflow  = ~ovf;
      chk("rsp_valid", 64'(rsp_valid), 64'(1) << g);
      chk("rsp_quotient", rsp_quotient, q);
      chk("rsp_remainder", 64'(rsp_remainder), 64'(r));
      chk("rsp_overflow", 64'(rsp_overflow), 64'(ovf));
      chk("ready_resp", 64'(req_ready), 64'd0);
      if (hold > 0) begin
         rsp_ready = ~(NR'(1) << g);
         repeat (hold) begin
            step();
            chk("bp_valid", 64'(rsp_valid), 64'(1) << g);
            chk("bp_quotient", rsp_quotient, q);
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_operand", div_dividend, dvd);
         end
         rsp_ready = '1;
      end
      step();
      chk("rsp_drop", 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      reset         = 1'b1;
      req_valid     = '0;
      req_dividend  = '0;
      req_divisor   = '0;
      rsp_ready     = '1;
      div_quotient  = '0;
      div_remainder = '0;
      div_overflow  = 1'b0;
      div_valid_out = 1'b0;
      step();
      step();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_div_start", 64'(div_start), 64'd0);
      chk("rst_quotient", rsp_quotient, 64'd0);
      chk("rst_div_dividend", div_dividend, 64'd0);
      reset = 1'b0;
      step();

      // Single request, divider latency 34 -> response at cycle 36.
      req_valid = 2'b01;
      run_txn(0, 64'h0000_0000_0001_9000, 32'h0000_0032, 34, 64'h800, 32'h0, 1'b0, 0);
      req_valid = '0;
      #1;
      chk("idle_no_ready", 64'(req_ready), 64'd0);

      // Reset while waiting on the divider.
      req_valid = 2'b01;
      req_dividend[0 +: DW] = 64'h1234;
      req_divisor[0 +: SW]  = 32'h3;
      step();
      step();
      req_valid = '0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("wrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("wrst_div_start", 64'(div_start), 64'd0);
      chk("wrst_quotient", rsp_quotient, 64'd0);
      chk("wrst_dividend", div_dividend, 64'd0);
      chk("wrst_req_ready", 64'(req_ready), 64'd0);
      div_valid_out = 1'b1;
      div_quotient  = 64'h5;
      step();
      div_valid_out = 1'b0;
      chk("stray_valid", 64'(rsp_valid), 64'd0);
      chk("stray_quotient", rsp_quotient, 64'd0);

      // Contention: grants alternate 0,1,0,1 starting from requester 0.
      req_valid = 2'b11;
      run_txn(0, 64'd100, 32'd7, 3, 64'd14, 32'd2, 1'b0, 0);
      run_txn(1, 64'd1000, 32'd10, 5, 64'd100, 32'd0, 1'b0, 0);
      run_txn(0, 64'h55, 32'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b1, 0);
      run_txn(1, 64'hFFFF, 32'h100, 4, 64'hFF, 32'hFF, 1'b0, 10);
      req_valid = '0;

      // Divider never answers.
      req_valid = 2'b01;
      req_dividend[0 +: DW] = 64'h77;
      req_divisor[0 +: SW]  = 32'h7;
      step();
      req_valid = '0;
      chk("tmo_start", 64'(div_start), 64'd1);
`ifdef DIV_TIMEOUT_EN
      repeat (TMO) step();
      chk("tmo_not_yet", 64'(rsp_valid), 64'd0);
      step();
      chk("tmo_valid", 64'(rsp_valid), 64'd1);
      chk("tmo_quotient", rsp_quotient, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("tmo_remainder", 64'(rsp_remainder), 64'd0);
      chk("tmo_overflow", 64'(rsp_overflow), 64'd1);
      rsp_ready = '0;
      div_valid_out = 1'b1;
      div_quotient  = 64'h7;
      step();
      div_valid_out = 1'b0;
      chk("tmo_stray", rsp_quotient, 64'hFFFF_FFFF_FFFF_FFFF);
      rsp_ready = '1;
      step();
      chk("tmo_drop", 64'(rsp_valid), 64'd0);
`else
      repeat (TMO + 4) step();
      chk("nowd_wait", 64'(rsp_valid), 64'd0);
      div_valid_out = 1'b1;
      div_quotient  = 64'h11;
      div_remainder = 32'h0;
      div_overflow  = 1'b0;
      step();
      div_valid_out = 1'b0;
      chk("nowd_valid", 64'(rsp_valid), 64'd1);
      chk("nowd_quotient", rsp_quotient, 64'h11);
      step();
      chk("nowd_drop", 64'(rsp_valid), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
